// File: rtl/project_pkg.sv
// ============================================================================
// Module : project_pkg
// Brief  : Shared display character codes, editor state type and helpers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package project_pkg;

    typedef logic [3:0] code_t;
    typedef code_t [7:0] disp_t;

    localparam code_t CHAR_0    = 4'h0;
    localparam code_t CHAR_1    = 4'h1;
    localparam code_t CHAR_2    = 4'h2;
    localparam code_t CHAR_3    = 4'h3;
    localparam code_t CHAR_4    = 4'h4;
    localparam code_t CHAR_5    = 4'h5;
    localparam code_t CHAR_6    = 4'h6;
    localparam code_t CHAR_7    = 4'h7;
    localparam code_t CHAR_8    = 4'h8;
    localparam code_t CHAR_9    = 4'h9;
    localparam code_t CHAR_DASH = 4'hA;
    localparam code_t CHAR_BLK  = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EDIT    = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } edit_state_t;

    function automatic code_t digit_to_code(input logic [3:0] d);
        code_t c;
        case (d)
            4'd0:    c = CHAR_0;
            4'd1:    c = CHAR_1;
            4'd2:    c = CHAR_2;
            4'd3:    c = CHAR_3;
            4'd4:    c = CHAR_4;
            4'd5:    c = CHAR_5;
            4'd6:    c = CHAR_6;
            4'd7:    c = CHAR_7;
            4'd8:    c = CHAR_8;
            4'd9:    c = CHAR_9;
            default: c = CHAR_BLK;
        endcase
        return c;
    endfunction

    // Dashes on the editable positions, blanks on the unused left-hand ones.
    function automatic disp_t idle_display(input int n_dig);
        disp_t d;
        for (int i = 0; i < 8; i++) begin
            d[i] = (i < n_dig) ? CHAR_DASH : CHAR_BLK;
        end
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/digit_entry_editor.sv
// ============================================================================
// Module : digit_entry_editor
// Brief  : Button-driven decimal digit editor with a one-digit-per-cycle
//          decimal-to-binary converter and a blinking cursor on the display.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module digit_entry_editor
    import project_pkg::*;
#(
    parameter int N_DIG   = 4,
    parameter int BLINK_W = 24,
    parameter int VAL_W   = 27
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_left,
    input  logic              btn_right,
    input  logic              btn_confirm,
    input  logic              btn_cancel,
    output code_t [7:0]       display_data,
    output logic  [7:0]       blink_mask,
    output logic              busy,
    output logic  [VAL_W-1:0] value,
    output logic              value_valid
);

    localparam logic [2:0]       c_last_idx  = 3'(N_DIG - 1);
    localparam logic [VAL_W-1:0] c_ten       = VAL_W'(10);
    localparam disp_t            c_idle_disp = idle_display(N_DIG);

    edit_state_t        state_q,  state_d;
    logic [7:0][3:0]    digits_q, digits_d;
    logic [2:0]         cursor_q, cursor_d;
    logic [BLINK_W-1:0] blink_q,  blink_d;
    logic [VAL_W-1:0]   acc_q,    acc_d;
    logic [2:0]         idx_q,    idx_d;
    logic [VAL_W-1:0]   value_q,  value_d;
    logic               valid_q,  valid_d;
    disp_t              disp_q,   disp_d;
    logic [7:0]         mask_q,   mask_d;
    logic               busy_q,   busy_d;

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        cursor_d = cursor_q;
        blink_d  = blink_q + 1'b1;
        acc_d    = acc_q;
        idx_d    = idx_q;
        value_d  = value_q;
        valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = EDIT;
                    digits_d = '0;
                    cursor_d = '0;
                    blink_d  = '0;
                end
            end
            EDIT: begin
                if (btn_cancel) begin
                    state_d = IDLE;
                end else if (btn_confirm) begin
                    state_d = CONVERT;
                    acc_d   = '0;
                    idx_d   = c_last_idx;
                end else if (btn_up) begin
                    digits_d[cursor_q] = (digits_q[cursor_q] == 4'd9) ? 4'd0
                                                                      : digits_q[cursor_q] + 4'd1;
                end else if (btn_down) begin
                    digits_d[cursor_q] = (digits_q[cursor_q] == 4'd0) ? 4'd9
                                                                      : digits_q[cursor_q] - 4'd1;
                end else if (btn_left) begin
                    cursor_d = (cursor_q == c_last_idx) ? 3'd0 : cursor_q + 3'd1;
                end else if (btn_right) begin
                    cursor_d = (cursor_q == 3'd0) ? c_last_idx : cursor_q - 3'd1;
                end
            end
            CONVERT: begin
                // Most significant digit first; the accumulator wraps at VAL_W bits.
                acc_d = (acc_q * c_ten) + VAL_W'(digits_q[idx_q]);
                if (idx_q == 3'd0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 3'd1;
                end
            end
            DONE: begin
                value_d = acc_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Display path is computed from the registered state so it lags by one cycle.
    always_comb begin
        disp_d = c_idle_disp;
        if (state_q != IDLE) begin
            for (int i = 0; i < 8; i++) begin
                disp_d[i] = (i < N_DIG) ? digit_to_code(digits_q[i]) : CHAR_BLK;
            end
        end

        mask_d = 8'hFF;
        if ((state_q == EDIT) && blink_q[BLINK_W-1]) begin
            mask_d[cursor_q] = 1'b0;
        end

        busy_d = (state_q == EDIT) || (state_q == CONVERT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            digits_q <= '0;
            cursor_q <= '0;
            blink_q  <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            disp_q   <= c_idle_disp;
            mask_q   <= 8'hFF;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            cursor_q <= cursor_d;
            blink_q  <= blink_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            disp_q   <= disp_d;
            mask_q   <= mask_d;
            busy_q   <= busy_d;
        end
    end

    assign display_data = disp_q;
    assign blink_mask   = mask_q;
    assign busy         = busy_q;
    assign value        = value_q;
    assign value_valid  = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_digit_entry_editor.sv
// ============================================================================
// Module : tb_digit_entry_editor
// Brief  : Scoreboard bench for digit_entry_editor (N_DIG=4 and N_DIG=8).
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_digit_entry_editor;
    import project_pkg::*;

    localparam int N  = 4;
    localparam int BW = 4;
    localparam int VW = 27;

    logic clk = 1'b0;
    logic rst;
    logic start, btn_up, btn_down, btn_left, btn_right, btn_confirm, btn_cancel;
    code_t [7:0]   disp4;
    logic [7:0]    mask4;
    logic          busy4;
    logic [VW-1:0] value4;
    logic          valid4;

    logic d8_start, d8_up, d8_down, d8_left, d8_right, d8_confirm, d8_cancel;
    code_t [7:0]   disp8;
    logic [7:0]    mask8;
    logic          busy8;
    logic [VW-1:0] value8;
    logic          valid8;

    digit_entry_editor #(.N_DIG(N), .BLINK_W(BW), .VAL_W(VW)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_confirm(btn_confirm), .btn_cancel(btn_cancel),
        .display_data(disp4), .blink_mask(mask4), .busy(busy4),
        .value(value4), .value_valid(valid4)
    );

    digit_entry_editor #(.N_DIG(8), .BLINK_W(BW), .VAL_W(VW)) u_dut8 (
        .clk(clk), .rst(rst), .start(d8_start),
        .btn_up(d8_up), .btn_down(d8_down), .btn_left(d8_left),
        .btn_right(d8_right), .btn_confirm(d8_confirm), .btn_cancel(d8_cancel),
        .display_data(disp8), .blink_mask(mask8), .busy(busy8),
        .value(value8), .value_valid(valid8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint val;
        int     due;
    } exp_t;
    exp_t sb[$];

    // Reference model: digit array, cursor and a coarse state (0 idle, 1 edit, 2 converting).
    int     m_dig[8];
    int     m_cur;
    int     m_state;
    int     s_cyc;
    longint m_value;
    code_t  tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint model_value();
        longint v  = 0;
        longint pw = 1;
        for (int i = 0; i < N; i++) begin
            v  += longint'(m_dig[i]) * pw;
            pw *= 10;
        end
        return v % (longint'(1) << VW);
    endfunction

    // Scoreboard monitor: every value_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && valid4 === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 64'(valid4), 64'd0);
            end else begin
                e = sb.pop_front();
                check("value", 64'(value4), 64'(e.val));
                check("valid_latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic press(input bit up, input bit dn, input bit lf, input bit rt,
                         input bit cf, input bit cn, input bit st);
        @(negedge clk);
        btn_up = up; btn_down = dn; btn_left = lf; btn_right = rt;
        btn_confirm = cf; btn_cancel = cn; start = st;
        @(posedge clk);
        #1;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        btn_confirm = 0; btn_cancel = 0; start = 0;
        case (m_state)
            0: if (st) begin
                m_state = 1;
                for (int i = 0; i < 8; i++) m_dig[i] = 0;
                m_cur = 0;
                s_cyc = cyc;
            end
            1: begin
                if (cn) m_state = 0;
                else if (cf) begin
                    m_value = model_value();
                    sb.push_back('{m_value, cyc + N + 1});
                    m_state = 2;
                end
                else if (up) m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
                else if (dn) m_dig[m_cur] = (m_dig[m_cur] + 9) % 10;
                else if (lf) m_cur = (m_cur + 1) % N;
                else if (rt) m_cur = (m_cur + N - 1) % N;
            end
            default: ;
        endcase
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) press(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_edit(input bit want_dark);
        disp_t      ed;
        logic [7:0] em;
        @(posedge clk);
        #1;
        if (want_dark) begin
            for (int k = 0; k < 16 && ((cyc - 1 - s_cyc) % 16) < 8; k++) begin
                @(posedge clk);
                #1;
            end
        end
        for (int i = 0; i < 8; i++) ed[i] = (i < N) ? tbl[m_dig[i]] : CHAR_BLK;
        em = 8'hFF;
        if (((cyc - 1 - s_cyc) % 16) >= 8) em[m_cur] = 1'b0;
        check("edit_display", 64'(disp4), 64'(ed));
        check("edit_mask", 64'(mask4), 64'(em));
        check("edit_busy", 64'(busy4), 64'd1);
    endtask

    task automatic check_idle(input string tag);
        disp_t ed;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) ed[i] = (i < N) ? CHAR_DASH : CHAR_BLK;
        check({tag, "_display"}, 64'(disp4), 64'(ed));
        check({tag, "_mask"}, 64'(mask4), 64'hFF);
        check({tag, "_busy"}, 64'(busy4), 64'd0);
        check({tag, "_value"}, 64'(value4), 64'(m_value));
    endtask

    task automatic finish_convert();
        for (int k = 0; k <= N; k++) begin
            press($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1));
        end
        m_state = 0;
    endtask

    task automatic d8_pulse(input int which);
        @(negedge clk);
        d8_start = (which == 0); d8_down = (which == 1);
        d8_left = (which == 2); d8_confirm = (which == 3);
        @(posedge clk);
        #1;
        d8_start = 0; d8_down = 0; d8_left = 0; d8_confirm = 0;
    endtask

    initial begin
        int     t;
        bit     seen;
        disp_t  ed;
        tbl = '{CHAR_0, CHAR_1, CHAR_2, CHAR_3, CHAR_4, CHAR_5, CHAR_6, CHAR_7, CHAR_8, CHAR_9};
        rst = 1'b1;
        start = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        btn_confirm = 0; btn_cancel = 0;
        d8_start = 0; d8_up = 0; d8_down = 0; d8_left = 0; d8_right = 0;
        d8_confirm = 0; d8_cancel = 0;
        m_state = 0; m_cur = 0; m_value = 0; s_cyc = 0;
        for (int i = 0; i < 8; i++) m_dig[i] = 0;

        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) ed[i] = (i < N) ? CHAR_DASH : CHAR_BLK;
        check("reset_display", 64'(disp4), 64'(ed));
        check("reset_mask", 64'(mask4), 64'hFF);
        check("reset_busy", 64'(busy4), 64'd0);
        check("reset_value", 64'(value4), 64'd0);
        check("reset_valid", 64'(valid4), 64'd0);
        rst = 1'b0;

        // Enter 73: three ups on digit 0, move left, seven ups on digit 1.
        press(0, 0, 0, 0, 0, 0, 1);
        check_edit(0);
        repeat (3) press(1, 0, 0, 0, 0, 0, 0);
        press(0, 0, 1, 0, 0, 0, 0);
        repeat (7) press(1, 0, 0, 0, 0, 0, 0);
        check_edit(1);
        press(0, 0, 0, 0, 1, 0, 0);
        idle_cycles(N + 1);
        m_state = 0;
        check_idle("after73");
        check("value_73", 64'(value4), 64'd73);

        // Digit and cursor wrap-around.
        press(0, 0, 0, 0, 0, 0, 1);
        press(0, 1, 0, 0, 0, 0, 0);
        check_edit(0);
        press(1, 0, 0, 0, 0, 0, 0);
        check_edit(0);
        press(0, 0, 0, 1, 0, 0, 0);
        check_edit(1);
        press(0, 0, 1, 0, 0, 0, 0);
        check_edit(1);

        // Simultaneous buttons: up beats left; cancel beats confirm.
        press(1, 0, 1, 0, 0, 0, 0);
        check_edit(1);
        press(0, 0, 0, 0, 1, 1, 0);
        check_idle("cancel_confirm");

        // Free-running cursor blink over two full periods.
        press(0, 0, 0, 0, 0, 0, 1);
        press(0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 32; k++) check_edit(0);
        press(0, 0, 0, 0, 0, 1, 0);
        check_idle("blink_exit");

        // Randomised entries.
        for (int e = 0; e < 20; e++) begin
            press(0, 0, 0, 0, 0, 0, 1);
            for (int k = 0; k < 15 && m_state == 1; k++) begin
                press($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
                      $urandom_range(0, 7) == 0);
                if (m_state == 1) check_edit($urandom_range(0, 1));
            end
            if (m_state == 1) press(0, 0, 0, 0, ($urandom_range(0, 4) != 0), 0, 0);
            if (m_state == 1) press(0, 0, 0, 0, 0, 1, 0);
            if (m_state == 2) finish_convert();
            check_idle("random");
        end

        // Reset in the second conversion cycle aborts the entry.
        press(0, 0, 0, 0, 0, 0, 1);
        press(1, 0, 0, 0, 0, 0, 0);
        press(0, 0, 0, 0, 1, 0, 0);
        press(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        void'(sb.pop_back());
        m_state = 0;
        m_value = 0;
        for (int i = 0; i < 8; i++) ed[i] = (i < N) ? CHAR_DASH : CHAR_BLK;
        check("abort_display", 64'(disp4), 64'(ed));
        check("abort_mask", 64'(mask4), 64'hFF);
        check("abort_value", 64'(value4), 64'd0);
        check("abort_busy", 64'(busy4), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_cycles(N + 4);
        check_idle("abort_after");

        // Eight nines on the wide instance.
        d8_pulse(0);
        for (int k = 0; k < 8; k++) begin
            d8_pulse(1);
            d8_pulse(2);
        end
        d8_pulse(3);
        t = cyc;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (valid8 === 1'b1) seen = 1;
        end
        check("d8_valid_seen", 64'(seen), 64'd1);
        check("d8_latency", 64'(cyc), 64'(t + 9));
        check("d8_value", 64'(value8), 64'd99999999);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
